comp_deb_nb: RTL
================

# comp_deb_nb

Registered, parametrised n-bit comparator with a signed/unsigned mode, a programmable equality tolerance band and a debounced "stable" result. It classifies each sampled operand pair as eq/lt/gt, registers the raw result, and promotes it to the stable outputs only after DEB consecutive identical classifications. It sits between sampled sensor values and control logic that must not react to single-sample noise near the crossover point.

## Interface

**Parameters**
- `n`, default 8: operand width (≥ 2).
- `TOL`, default 0: equality tolerance, unsigned, legal range 0 .. 2^(n-1)-1.
- `DEB`, default 4: consecutive identical samples required to update the stable result (≥ 1).

**Ports**
- `clk`, input, 1: the only clock; all state changes on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: sample strobe; `a`, `b` and `sgn` are sampled on edges where `en`=1.
- `sgn`, input, 1: 1 = two's-complement compare, 0 = unsigned compare; applies per sample.
- `a`, input, n: operand A.
- `b`, input, n: operand B.
- `valid`, output, 1: high for the one cycle after a sampled edge.
- `eq`, `lt`, `gt`, output, 1 each: registered raw classification of the last sample.
- `s_eq`, `s_lt`, `s_gt`, output, 1 each: debounced stable classification.
- `chg`, output, 1: one-cycle pulse when the stable result changes.

## Operation

- **Extension:**
  - `sgn`=1: sign-extend `a` and `b` to n+2 bits.
  - `sgn`=0: zero-extend `a` and `b` to n+2 bits.
  - Compute d = A − B in n+2 bits. This width cannot overflow.
- **Classification:**
  - |d| ≤ TOL → eq.
  - d > TOL → gt.
  - d < −TOL → lt.
  - Exactly one class per sample.
- **Raw stage:** on an edge with `en`=1, `{eq,lt,gt}` load the class and `valid` is set. On an edge with `en`=0, `{eq,lt,gt}` hold and `valid` clears.
- **Debounce state:** a candidate class `cand`, which may be "none", and a saturating counter `cnt` of width clog2(DEB+1).
  - On an `en`=1 edge where class == `cand`: cnt ← min(cnt+1, DEB).
  - On an `en`=1 edge where class ≠ `cand`: cand ← class, cnt ← 1.
  - On `en`=0 edges, `cand` and `cnt` hold. Gaps in `en` do not break a run.
- **Stable update:** on an `en`=1 edge where the next cnt == DEB and the next cand ≠ the current stable class:
  - `{s_eq,s_lt,s_gt}` load the next cand.
  - `chg` is 1 for that one cycle.
  - Otherwise `chg` is 0 and the stable outputs hold.
- **DEB = 1:** the stable outputs follow the raw outputs on the same edge.
- **Reset values:** every output is 0 (`valid`, `eq`, `lt`, `gt`, `s_eq`, `s_lt`, `s_gt`, `chg`). `cand` = none, `cnt` = 0. The stable class "none" differs from every real class, so the first qualification always pulses `chg`.
- **Reset mid-run:** asserting `rst_n` low clears all state immediately, with no wait for `clk`. Counting restarts from zero after release.
- **Mode switching:** changing `sgn` between samples needs no flush. Each sample is classified under its own `sgn`, and runs continue when the class is unchanged.

## Timing

- Throughput: one sample per clock.
- Latency from an `en`=1 edge to raw outputs and `valid`: 1 edge. Outputs are visible after the sampling edge.
- Stable latency: the stable outputs and `chg` update on the edge of the DEB-th consecutive identical sample. There is no extra pipeline stage.
- `chg` and `valid` are single-cycle pulses and never stretch across `en`=0 cycles.
- Outputs are registered only, with no combinational path from inputs to outputs.
- `rst_n` deassertion is synchronous to `clk` at the system level. The block requires no synchroniser internally.

## Test plan

- **Reset:** hold `rst_n`=0 with random inputs and toggle `en` → all outputs stay 0. Release, then sample a=5, b=5 → `eq`=1 and `valid`=1 one cycle later. `s_*` stay 0 until DEB samples.
- **Mode (n=8, TOL=0, DEB=1):**
  - a=0x80, b=0x7F, sgn=0 → `gt`=1.
  - Same operands, sgn=1 → `lt`=1.
  - a=0xFF, b=0x00: sgn=1 → `lt`, sgn=0 → `gt`.
  - `chg` pulses at each stable change.
- **Tolerance (TOL=2):**
  - a=10, b=12 → `eq`.
  - a=10, b=13 → `lt`.
  - a=0x7F, b=0x80, sgn=1 → `gt`, with no overflow.
  - a=0xFF, b=0x00, sgn=0 → `gt`.
- **Debounce (DEB=4):**
  - 4× gt → `s_gt`=1 and `chg` pulses on the 4th edge.
  - Then 3× lt, 1× gt, 3× lt → `s_gt` holds and `chg`=0 throughout.
  - A 4th consecutive lt → `s_lt`=1 and `chg` pulses for 1 cycle.
- **En gaps:** 2× eq samples, 5 idle cycles with `en`=0, then 2× eq → `s_eq` set on the 4th sample. `valid` and `chg` stay low during the idle cycles.
- **Reset mid-count:** 3× lt, then pulse `rst_n` low between edges → outputs clear before the next edge. A further 3× lt after release does not set `s_lt`. The 4th does.

Source files
------------

// File: rtl/comp_deb_nb.sv
// comp_deb_nb: registered signed/unsigned n-bit comparator with an equality
// tolerance band and a debounced stable classification.
//
// Each sampled pair is extended to n+2 bits, subtracted, and classified as
// eq/lt/gt against the tolerance. The raw class is registered directly. The
// stable class only moves after DEB consecutive identical classifications.
// Edges with en=0 neither extend nor break a run.
module comp_deb_nb #(
  parameter int n   = 8,
  parameter int TOL = 0,
  parameter int DEB = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         sgn,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         valid,
  output logic         eq,
  output logic         lt,
  output logic         gt,
  output logic         s_eq,
  output logic         s_lt,
  output logic         s_gt,
  output logic         chg
);

  // Two guard bits: the difference of two n-bit values in either mode fits in n+2 bits.
  localparam int W  = n + 2;
  localparam int CW = $clog2(DEB + 1);

  localparam logic [CW-1:0]       DEB_C = CW'(DEB);
  localparam logic [CW-1:0]       ONE_C = CW'(1);
  localparam logic signed [W-1:0] TOL_P = W'(TOL);
  localparam logic signed [W-1:0] TOL_N = W'(-TOL);

  // The CLS_NONE encoding never equals a real class.
  // This makes the first qualification after reset always register as a change.
  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_EQ   = 2'd1,
    CLS_LT   = 2'd2,
    CLS_GT   = 2'd3
  } cls_t;

  // One-hot {eq,lt,gt} view of a class; none maps to all zeros.
  function automatic logic [2:0] cls_onehot(input cls_t c);
    logic [2:0] oh;
    case (c)
      CLS_EQ:  oh = 3'b100;
      CLS_LT:  oh = 3'b010;
      CLS_GT:  oh = 3'b001;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  logic signed [W-1:0] a_x_s;
  logic signed [W-1:0] b_x_s;
  logic signed [W-1:0] d_s;
  cls_t                cls_s;
  cls_t                cand_r;
  cls_t                cand_n_s;
  logic [CW-1:0]       cnt_r;
  logic [CW-1:0]       cnt_n_s;
  cls_t                stab_s;
  logic                upd_s;

  // Extend the operands per the current mode, subtract, and classify against the tolerance band.
  always_comb begin
    if (sgn) begin
      a_x_s = {{2{a[n-1]}}, a};
      b_x_s = {{2{b[n-1]}}, b};
    end else begin
      a_x_s = {2'b00, a};
      b_x_s = {2'b00, b};
    end
    d_s = a_x_s - b_x_s;
    if (d_s > TOL_P) begin
      cls_s = CLS_GT;
    end else if (d_s < TOL_N) begin
      cls_s = CLS_LT;
    end else begin
      cls_s = CLS_EQ;
    end
  end

  // Debounce next state: extend the run on a repeat, restart it on a new class, hold when idle.
  always_comb begin
    cand_n_s = cand_r;
    cnt_n_s  = cnt_r;
    if (en) begin
      if (cls_s == cand_r) begin
        if (cnt_r >= DEB_C) begin
          cnt_n_s = DEB_C;
        end else begin
          cnt_n_s = cnt_r + ONE_C;
        end
      end else begin
        cand_n_s = cls_s;
        cnt_n_s  = ONE_C;
      end
    end else begin
      cand_n_s = cand_r;
      cnt_n_s  = cnt_r;
    end
  end

  // Stable-update decision: a fully qualified candidate that differs from the current stable class.
  always_comb begin
    case ({s_eq, s_lt, s_gt})
      3'b100:  stab_s = CLS_EQ;
      3'b010:  stab_s = CLS_LT;
      3'b001:  stab_s = CLS_GT;
      default: stab_s = CLS_NONE;
    endcase
    if (en && (cnt_n_s == DEB_C) && (cand_n_s != stab_s)) begin
      upd_s = 1'b1;
    end else begin
      upd_s = 1'b0;
    end
  end

  // State and output registers: raw class, debounce run, stable class and pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      eq     <= 1'b0;
      lt     <= 1'b0;
      gt     <= 1'b0;
      s_eq   <= 1'b0;
      s_lt   <= 1'b0;
      s_gt   <= 1'b0;
      chg    <= 1'b0;
      cand_r <= CLS_NONE;
      cnt_r  <= '0;
    end else begin
      valid  <= en;
      chg    <= upd_s;
      cand_r <= cand_n_s;
      cnt_r  <= cnt_n_s;
      if (en) begin
        {eq, lt, gt} <= cls_onehot(cls_s);
      end
      if (upd_s) begin
        {s_eq, s_lt, s_gt} <= cls_onehot(cand_n_s);
      end
    end
  end

endmodule
